// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcodes, decode masks, state codes, ALU and immediate selects.
// Used by the controller, the opcode decoder and the datapath so every encoding has a single source.
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    // A 1 in a mask marks an opcode bit that must match; 0 bits belong to the immediate field.
    localparam logic [10:0] MASK_FULL = 11'b11111111111;
    localparam logic [10:0] MASK_I    = 11'b11111111110;
    localparam logic [10:0] MASK_CB   = 11'b11111111000;
    localparam logic [10:0] MASK_B    = 11'b11111100000;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM_RD = 3'd3;
    localparam logic [2:0] ST_MEM_WR = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_BRANCH = 3'd6;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    typedef enum logic [2:0] {
        FETCH  = ST_FETCH,
        DECODE = ST_DECODE,
        EXEC   = ST_EXEC,
        MEM_RD = ST_MEM_RD,
        MEM_WR = ST_MEM_WR,
        WB     = ST_WB,
        BRANCH = ST_BRANCH,
        FAULT  = ST_FAULT
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_B  = 2'b00;
    localparam logic [1:0] IMM_I  = 2'b01;
    localparam logic [1:0] IMM_D  = 2'b10;
    localparam logic [1:0] IMM_CB = 2'b11;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_D, CLS_CB, CLS_B, CLS_ILL
    } op_class_t;

    function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                      input logic [10:0] mask);
        return ((op ^ pat) & mask) == 11'd0;
    endfunction

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: master is the controller, slave is the datapath side.
interface legv8_multicycle_ctrl_if #(parameter int RETIRE_W = 32);
    logic [10:0]         opcode;
    logic                alu_zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_read;
    logic                mem_write;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                reg_write;
    logic                mem_to_reg;
    logic                alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          imm_sel;
    logic                fault;
    logic [2:0]          state_dbg;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, alu_src_b, alu_op, imm_sel, fault, state_dbg, retired
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, alu_src_b, alu_op, imm_sel, fault, state_dbg, retired
    );
endinterface

// File: rtl/legv8_opdecode.sv
// Combinational LEGv8 opcode classifier: class, illegal flag, load flag, ALU op and immediate format.
import legv8_pkg::*;
module legv8_opdecode (
    input  logic [10:0] opcode,
    output op_class_t   op_class,
    output logic        illegal,
    output logic        is_load,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_sel
);
    always_comb begin
        op_class = CLS_ILL;
        is_load  = 1'b0;
        alu_op   = ALU_ADD;
        imm_sel  = IMM_B;
        if (op_match(opcode, OP_ADD, MASK_FULL)) begin
            op_class = CLS_R;
        end else if (op_match(opcode, OP_SUB, MASK_FULL)) begin
            op_class = CLS_R;
            alu_op   = ALU_SUB;
        end else if (op_match(opcode, OP_AND, MASK_FULL)) begin
            op_class = CLS_R;
            alu_op   = ALU_AND;
        end else if (op_match(opcode, OP_ORR, MASK_FULL)) begin
            op_class = CLS_R;
            alu_op   = ALU_ORR;
        end else if (op_match(opcode, OP_ADDI, MASK_I)) begin
            op_class = CLS_I;
            imm_sel  = IMM_I;
        end else if (op_match(opcode, OP_SUBI, MASK_I)) begin
            op_class = CLS_I;
            alu_op   = ALU_SUB;
            imm_sel  = IMM_I;
        end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
            op_class = CLS_D;
            is_load  = 1'b1;
            imm_sel  = IMM_D;
        end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
            op_class = CLS_D;
            imm_sel  = IMM_D;
        end else if (op_match(opcode, OP_CBZ, MASK_CB)) begin
            op_class = CLS_CB;
            imm_sel  = IMM_CB;
        end else if (op_match(opcode, OP_B, MASK_B)) begin
            op_class = CLS_B;
        end
        illegal = (op_class == CLS_ILL);
    end
endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory wait timeout, retire count.
// Strobes are decoded from state plus mem_ready/alu_zero; FAULT is sticky until reset.
import legv8_pkg::*;
module legv8_multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int RETIRE_W     = 32
) (
    input logic                      clk,
    input logic                      rst_n,
    legv8_multicycle_ctrl_if.master  bus
);
    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    state_t              state;
    logic [7:0]          wait_cnt;
    logic [RETIRE_W-1:0] retired_q;
    logic                fault_q;

    op_class_t  op_class;
    logic       op_illegal;
    logic       op_load;
    logic [1:0] dec_alu_op;
    logic [1:0] dec_imm_sel;

    legv8_opdecode u_opdecode (
        .opcode   (bus.opcode),
        .op_class (op_class),
        .illegal  (op_illegal),
        .is_load  (op_load),
        .alu_op   (dec_alu_op),
        .imm_sel  (dec_imm_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            // The wait counter only survives a cycle spent stalled in a memory state.
            wait_cnt <= '0;
            unique case (state)
                FETCH, MEM_RD, MEM_WR: begin
                    if (bus.mem_ready) begin
                        if (state == FETCH) begin
                            state <= DECODE;
                        end else if (state == MEM_RD) begin
                            state <= WB;
                        end else begin
                            state     <= FETCH;
                            retired_q <= retired_q + RETIRE_W'(1);
                        end
                    end else if (wait_cnt == WAIT_MAX) begin
                        state   <= FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DECODE: begin
                    if (op_illegal) begin
                        state   <= FAULT;
                        fault_q <= 1'b1;
                    end else if (op_class == CLS_CB || op_class == CLS_B) begin
                        state <= BRANCH;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_class)
                        CLS_R, CLS_I: state <= WB;
                        CLS_D:        state <= op_load ? MEM_RD : MEM_WR;
                        default: begin
                            state   <= FAULT;
                            fault_q <= 1'b1;
                        end
                    endcase
                end
                WB, BRANCH: begin
                    state     <= FETCH;
                    retired_q <= retired_q + RETIRE_W'(1);
                end
                FAULT: fault_q <= 1'b1;
            endcase
        end
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_b  = 1'b0;
        bus.alu_op     = dec_alu_op;
        bus.imm_sel    = dec_imm_sel;
        case (state)
            FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_read = 1'b1;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            EXEC: begin
                bus.alu_src_b = (op_class == CLS_I) || (op_class == CLS_D);
                if (op_class == CLS_D) bus.alu_op = ALU_ADD;
            end
            MEM_RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            MEM_WR: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = op_load;
            end
            BRANCH: begin
                if (op_class == CLS_B) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 1'b1;
                end else if (op_class == CLS_CB) begin
                    bus.pc_write = bus.alu_zero;
                    bus.pc_src   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.fault     = fault_q;
    assign bus.state_dbg = state;
    assign bus.retired   = retired_q;

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the LEGv8 datapath (PC, IR, register file, ALU, immediate sign-extender, unified memory) across FETCH/DECODE/EXEC/MEM/WB.
- Decodes the 11-bit opcode field, drives per-state control strobes and the immediate-format select, and runs the single memory request/ready handshake.
- Traps illegal opcodes and memory timeouts into a sticky fault state and counts retired instructions.

Parameters:
- MEM_WAIT_MAX, 15: maximum wait cycles for mem_ready per request before fault (1..255).
- RETIRE_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  11  IR[31:21] from the datapath instruction register.
- alu_zero  in  1  ALU zero flag (valid in BRANCH).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_read  out  1  read request qualifier.
- mem_write  out  1  write request qualifier.
- iord  out  1  address source: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR (one-cycle pulse).
- pc_write  out  1  load PC.
- pc_src  out  1  0 = PC+4, 1 = branch target (old_pc + imm<<2).
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 0 = ALU, 1 = memory data register.
- alu_src_b  out  1  0 = register Rm, 1 = extended immediate.
- alu_op  out  2  00 add, 01 sub, 10 and, 11 orr.
- imm_sel  out  2  00 B (26-bit), 01 I (12-bit zero-ext), 10 D (9-bit), 11 CB (19-bit).
- fault  out  1  sticky; 1 in FAULT.
- state_dbg  out  3  current state encoding.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- Reset: when rst_n = 0 at a rising edge, state <= FETCH, wait counter <= 0, retired <= 0, fault <= 0. The reset takes effect even mid-request: mem_req drops on the following cycle with no completion.
- Outputs are Moore/Mealy from state and inputs. Every strobe is 0 unless listed for the current state. imm_sel and alu_op are decoded from opcode in every state.
- Decode classes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → R.
  - ADDI 1001000100x, SUBI 1101000100x → I.
  - LDUR 11111000010, STUR 11111000000 → D.
  - CBZ 10110100xxx → CB.
  - B 000101xxxxx → B.
  - Anything else → illegal.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM_RD 3, MEM_WR 4, WB 5, BRANCH 6, FAULT 7.
- FETCH: mem_req = 1, mem_read = 1, iord = 0.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0; next state DECODE.
- DECODE: no strobes.
  - R, I or D → EXEC.
  - CB or B → BRANCH.
  - Illegal → FAULT.
- EXEC: alu_src_b = 1 for I/D, 0 for R. D forces alu_op = 00.
  - R or I → WB.
  - LDUR → MEM_RD.
  - STUR → MEM_WR.
- MEM_RD: mem_req = 1, mem_read = 1, iord = 1. When mem_ready = 1 → WB.
- MEM_WR: mem_req = 1, mem_write = 1, iord = 1. When mem_ready = 1 → FETCH; retired increments.
- WB: reg_write = 1; mem_to_reg = 1 iff opcode is LDUR. Next state FETCH; retired increments.
- BRANCH:
  - B: pc_write = 1, pc_src = 1.
  - CBZ: pc_write = alu_zero, pc_src = 1.
  - Next state FETCH; retired increments.
- FAULT: fault = 1, all strobes 0. Only reset exits.
- Wait counter:
  - Cleared on every transition into FETCH, MEM_RD or MEM_WR.
  - Increments each cycle the FSM is in one of those states with mem_ready = 0.
  - If it reaches MEM_WAIT_MAX with mem_ready = 0 → FAULT next cycle.
  - If mem_ready = 1 in the same cycle the counter equals MEM_WAIT_MAX, the completion wins.
- retired wraps modulo 2^RETIRE_W with no saturation.
- Latencies with zero memory wait:
  - R/I: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - B/CBZ: 3 cycles.

Decomposition:
- Shared package legv8_pkg holds:
  - the opcode constants and don't-care masks;
  - the state encoding localparams;
  - the alu_op and imm_sel codes, so the datapath and the immediate extender share one definition.
- One sub-module, legv8_opdecode: combinational opcode → {class, illegal, alu_op, imm_sel}. The FSM, wait counter and retire counter stay in the top module.

Test Plan:
- ADD opcode, mem_ready tied 1 → states 0,1,2,5,0. reg_write = 1 in cycle 4 only, alu_src_b = 0, alu_op = 00, retired = 1.
- LDUR with mem_ready low for 3 cycles in MEM_RD → mem_req held 4 cycles with iord = 1, then WB with mem_to_reg = 1. Total 8 cycles, retired = 1, imm_sel = 10.
- CBZ with alu_zero = 1, then again with alu_zero = 0 → pc_write = 1/pc_src = 1 in BRANCH on the first, pc_write = 0 on the second. imm_sel = 11, retired = 2.
- Opcode 11111111111 → DECODE→FAULT, fault = 1, state_dbg = 7, retired unchanged. Holds for 20 cycles until rst_n = 0.
- MEM_WAIT_MAX = 4, mem_ready never asserted in FETCH → FAULT entered 5 cycles after reset release. With mem_ready = 1 exactly at count 4 → DECODE instead, no fault.
- rst_n = 0 for one cycle while in MEM_WR waiting → next cycle state = FETCH, mem_write = 0, retired = 0, wait counter = 0.
